pong_game_ctrl: RTL and testbench

- Parametrised game-flow controller for the pong design: an FSMD that sequences new game, play, serve wait and game over.
- Sits between the keyboard decoder, pong_graph (hit/miss), the score counter and the text overlay.
- Generalises the current game control to N players, a configurable ball count, a frame-tick-based serve/over timer and an optional win-by-score rule.
- Reports the winner; has an optional pause state.

---
 rtl/pong_game_ctrl.sv | 158 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Game-flow FSMD for pong: new game, play, serve wait, game over, with N players and winner report.
// Optional pause state is built when GAME_PAUSE_EN is defined.
module pong_game_ctrl #(
  parameter int N_PLAYERS    = 2,
  parameter int BALLS        = 3,
  parameter int WIN_SCORE    = 0,
  parameter int SERVE_FRAMES = 120,
  parameter int OVER_FRAMES  = 120,
  parameter int SERVE_ALL    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic [2*N_PLAYERS-1:0] btn,
  input  logic [N_PLAYERS-1:0]   hit,
  input  logic                   miss,
  input  logic                   pause,
  output logic                   gra_still,
  output logic                   d_clr,
  output logic [N_PLAYERS-1:0]   d_inc,
  output logic [3:0]             balls_left,
  output logic [2:0]             state,
  output logic [N_PLAYERS-1:0]   winner
);

  typedef enum logic [2:0] {
    S_NEWGAME = 3'd0,
    S_PLAY    = 3'd1,
    S_NEWBALL = 3'd2,
    S_OVER    = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  localparam logic [3:0] BALLS_T = 4'(BALLS);
  localparam logic [7:0] WIN_T   = 8'(WIN_SCORE);
  localparam logic [7:0] SERVE_T = 8'(SERVE_FRAMES);
  localparam logic [7:0] OVER_T  = 8'(OVER_FRAMES);

  state_t               st, st_next;
  logic [3:0]           balls_next;
  logic [N_PLAYERS-1:0] d_inc_next, winner_next;
  logic [7:0]           timer, timer_next;
  logic [7:0]           points [N_PLAYERS];
  logic [7:0]           points_next [N_PLAYERS];
  logic [7:0]           post [N_PLAYERS];
  logic [N_PLAYERS-1:0] win_hit, first_win, max_hot;
  logic [7:0]           max_pts;
  logic                 timer_up, serve_ok, all_ok, tie_free, pause_rise;

`ifdef GAME_PAUSE_EN
  logic pause_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pause_q <= 1'b0;
    else       pause_q <= pause;
  end

  assign pause_rise = pause & ~pause_q;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_rise   = 1'b0;
`endif

  assign state     = st;
  assign gra_still = (st != S_PLAY);
  assign d_clr     = (st == S_NEWGAME);
  assign timer_up  = (st == S_OVER) ? (timer >= OVER_T) : (timer >= SERVE_T);

  // Score bookkeeping: post-hit points, early-win detection and unique-maximum winner
  always_comb begin
    all_ok  = 1'b1;
    max_pts = 8'd0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      all_ok     = all_ok & (|btn[2*p +: 2]);
      post[p]    = (hit[p] && points[p] != 8'hFF) ? points[p] + 8'd1 : points[p];
      win_hit[p] = (WIN_SCORE != 0) && hit[p] && (post[p] == WIN_T);
      if (points[p] > max_pts) max_pts = points[p];
    end
    for (int p = 0; p < N_PLAYERS; p++) max_hot[p] = (points[p] == max_pts);
    serve_ok  = (SERVE_ALL != 0) ? all_ok : (|btn);
    tie_free  = ((max_hot & (max_hot - N_PLAYERS'(1))) == '0);
    first_win = win_hit & (~win_hit + N_PLAYERS'(1));
  end

  always_comb begin
    st_next     = st;
    balls_next  = balls_left;
    d_inc_next  = '0;
    winner_next = winner;
    points_next = points;
    timer_next  = timer;
    if (frame_tick && (st == S_NEWBALL || st == S_OVER) && timer != 8'hFF)
      timer_next = timer + 8'd1;
    case (st)
      S_NEWGAME: begin
        balls_next  = BALLS_T;
        winner_next = '0;
        for (int p = 0; p < N_PLAYERS; p++) points_next[p] = 8'd0;
        if (|btn) st_next = S_PLAY;
      end
      S_PLAY: begin
        if (pause_rise) begin
          st_next = S_PAUSE;
        end else if (|hit) begin
          // A hit in the same cycle as a miss wins; the miss is dropped
          d_inc_next  = hit;
          points_next = post;
          if (|win_hit) begin
            st_next     = S_OVER;
            winner_next = first_win;
          end
        end else if (miss) begin
          balls_next = balls_left - 4'd1;
          if (balls_left == 4'd1) begin
            st_next     = S_OVER;
            winner_next = tie_free ? max_hot : '0;
          end else begin
            st_next = S_NEWBALL;
          end
        end
      end
      S_NEWBALL: if (timer_up && serve_ok) st_next = S_PLAY;
      S_OVER: begin
        if (timer_up) begin
          st_next     = S_NEWGAME;
          winner_next = '0;
        end
      end
      S_PAUSE:   if (pause_rise) st_next = S_PLAY;
      default:   st_next = S_NEWGAME;
    endcase
    if (st_next != st && (st_next == S_NEWBALL || st_next == S_OVER))
      timer_next = 8'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= S_NEWGAME;
    else       st <= st_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      balls_left <= BALLS_T;
      d_inc      <= '0;
      winner     <= '0;
      timer      <= 8'd0;
      for (int p = 0; p < N_PLAYERS; p++) points[p] <= 8'd0;
    end else begin
      balls_left <= balls_next;
      d_inc      <= d_inc_next;
      winner     <= winner_next;
      timer      <= timer_next;
      points     <= points_next;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl: default instance plus a WIN_SCORE=3 instance.
// The pause sequence is exercised only when GAME_PAUSE_EN is defined.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       miss = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [1:0] hit = 2'b00;

  logic       gra_still, d_clr, w_gra_still, w_d_clr;
  logic [1:0] d_inc, winner, w_d_inc, w_winner;
  logic [3:0] balls_left, w_balls_left;
  logic [2:0] state, w_state;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn), .hit(hit),
    .miss(miss), .pause(pause), .gra_still(gra_still), .d_clr(d_clr),
    .d_inc(d_inc), .balls_left(balls_left), .state(state), .winner(winner)
  );

  pong_game_ctrl #(.WIN_SCORE(3)) dut_w (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn), .hit(hit),
    .miss(miss), .pause(pause), .gra_still(w_gra_still), .d_clr(w_d_clr),
    .d_inc(w_d_inc), .balls_left(w_balls_left), .state(w_state), .winner(w_winner)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one set of inputs for n cycles, then drop the pulse inputs
  task automatic applyStimulus(input logic [3:0] b, input logic [1:0] h, input logic m,
                               input logic f, input int n);
    btn = b; hit = h; miss = m; frame_tick = f;
    repeat (n) @(negedge clk);
    hit = 2'b00; miss = 1'b0; frame_tick = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_gra", gra_still, 1);
    checkOutput("rst_dclr", d_clr, 1);
    checkOutput("rst_balls", balls_left, 3);
    checkOutput("rst_dinc", d_inc, 0);
    checkOutput("rst_winner", winner, 0);
    reset = 1'b0;

    applyStimulus(4'b0001, 2'b00, 0, 0, 1);
    checkOutput("start_state", state, 1);
    checkOutput("start_gra", gra_still, 0);
    checkOutput("start_dclr", d_clr, 0);
    checkOutput("start_balls", balls_left, 3);

    applyStimulus(4'b0000, 2'b10, 0, 0, 1);
    checkOutput("hit10_dinc", d_inc, 2'b10);
    applyStimulus(4'b0000, 2'b00, 0, 0, 1);
    checkOutput("hit10_pulse_end", d_inc, 2'b00);
    applyStimulus(4'b0000, 2'b11, 0, 0, 1);
    checkOutput("hit11_dinc", d_inc, 2'b11);
    applyStimulus(4'b0000, 2'b01, 1, 0, 1);
    checkOutput("hitmiss_dinc", d_inc, 2'b01);
    checkOutput("hitmiss_balls", balls_left, 3);
    checkOutput("hitmiss_state", state, 1);

    applyStimulus(4'b0000, 2'b00, 1, 0, 1);
    checkOutput("miss1_state", state, 2);
    checkOutput("miss1_balls", balls_left, 2);
    checkOutput("miss1_dinc", d_inc, 0);
    applyStimulus(4'b0101, 2'b00, 0, 1, 119);
    checkOutput("serve119_state", state, 2);
    applyStimulus(4'b0101, 2'b00, 0, 1, 1);
    applyStimulus(4'b0101, 2'b00, 0, 0, 1);
    checkOutput("serve120_state", state, 1);

    applyStimulus(4'b0000, 2'b00, 1, 0, 1);
    checkOutput("miss2_state", state, 2);
    checkOutput("miss2_balls", balls_left, 1);
    applyStimulus(4'b0001, 2'b00, 0, 1, 125);
    checkOutput("serve_one_btn", state, 2);
    applyStimulus(4'b0101, 2'b00, 0, 0, 1);
    checkOutput("serve_all_btn", state, 1);

    // Points now p0=2, p1=2; one more p0 hit gives p0 the unique lead
    applyStimulus(4'b0000, 2'b01, 0, 0, 1);
    checkOutput("w_early_win_state", w_state, 3);
    checkOutput("w_early_win_winner", w_winner, 2'b01);
    applyStimulus(4'b0000, 2'b00, 1, 0, 1);
    checkOutput("over_state", state, 3);
    checkOutput("over_balls", balls_left, 0);
    checkOutput("over_winner", winner, 2'b01);
    applyStimulus(4'b1111, 2'b00, 0, 1, 119);
    checkOutput("over119_state", state, 3);
    checkOutput("over119_winner", winner, 2'b01);
    applyStimulus(4'b0000, 2'b00, 0, 1, 1);
    applyStimulus(4'b0000, 2'b00, 0, 0, 1);
    checkOutput("over_done_state", state, 0);
    checkOutput("over_done_winner", winner, 0);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("w_rst_state", w_state, 0);
    applyStimulus(4'b0001, 2'b00, 0, 0, 1);
    applyStimulus(4'b0000, 2'b10, 0, 0, 1);
    applyStimulus(4'b0000, 2'b10, 0, 0, 1);
    checkOutput("w_two_hits_state", w_state, 1);
    checkOutput("w_two_hits_winner", w_winner, 0);
    applyStimulus(4'b0000, 2'b10, 0, 0, 1);
    checkOutput("w_win_state", w_state, 3);
    checkOutput("w_win_winner", w_winner, 2'b10);
    checkOutput("w_win_balls", w_balls_left, 3);
    checkOutput("nowin_state", state, 1);

    // Asynchronous reset while a d_inc pulse is live
    hit = 2'b10;
    @(posedge clk);
    #2;
    checkOutput("pre_rst_dinc", d_inc, 2'b10);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_state", state, 0);
    checkOutput("async_rst_dinc", d_inc, 0);
    checkOutput("async_rst_balls", balls_left, 3);
    hit = 2'b00;
    @(negedge clk);
    reset = 1'b0;

    // After reset no points survive, so an all-miss game is a tie
    applyStimulus(4'b0001, 2'b00, 0, 0, 1);
    applyStimulus(4'b0000, 2'b00, 1, 0, 1);
    applyStimulus(4'b0101, 2'b00, 0, 1, 121);
    checkOutput("tie_serve1", state, 1);
    applyStimulus(4'b0000, 2'b00, 1, 0, 1);
    applyStimulus(4'b0101, 2'b00, 0, 1, 121);
    checkOutput("tie_serve2", state, 1);
    applyStimulus(4'b0000, 2'b00, 1, 0, 1);
    checkOutput("tie_state", state, 3);
    checkOutput("tie_winner", winner, 0);
    checkOutput("tie_balls", balls_left, 0);

`ifdef GAME_PAUSE_EN
    applyStimulus(4'b0000, 2'b00, 0, 1, 121);
    checkOutput("pz_newgame", state, 0);
    applyStimulus(4'b0001, 2'b00, 0, 0, 1);
    pause = 1'b1;
    applyStimulus(4'b0000, 2'b00, 0, 0, 1);
    pause = 1'b0;
    checkOutput("pz_state", state, 4);
    checkOutput("pz_gra", gra_still, 1);
    applyStimulus(4'b0000, 2'b00, 1, 0, 1);
    checkOutput("pz_miss_state", state, 4);
    checkOutput("pz_miss_balls", balls_left, 3);
    pause = 1'b1;
    applyStimulus(4'b0000, 2'b00, 0, 0, 1);
    pause = 1'b0;
    checkOutput("pz_resume_state", state, 1);
    checkOutput("pz_resume_balls", balls_left, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
